divider_6: RTL



---
 rtl/divider_6_pkg.sv | 22 ++
 rtl/div_step_6.sv | 30 +++
 rtl/divider_6.sv | 131 +++++++++++++
 3 files changed

// File: rtl/divider_6_pkg.sv
// Shared types and constants for the divider_6 sign-magnitude divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_6_pkg;

  // Default operand magnitude widths: 16-bit dividend, 8-bit divisor.
  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  // Iteration counter width for the default dividend width.
  localparam int CNT_W = $clog2(DW_DEF);

  // Saturated quotient magnitude returned on divide-by-zero.
  localparam logic [DW_DEF-1:0] Q_SAT = {DW_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step_6.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: combinational.
// Backpressure: none.
module div_step_6 #(
  parameter int VW = 8
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] div,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW:0]   shifted;
  logic [VW+1:0] diff;
  logic          unused_rem_msb;

  // The partial remainder entering a step is always below the divisor, so
  // its MSB is zero and dropping it on the shift loses nothing.
  assign unused_rem_msb = rem_in[VW];

  // Shift, trial subtract, and pick the restored or reduced remainder.
  always_comb begin
    shifted = {rem_in[VW-1:0], bit_in};
    diff    = {1'b0, shifted} - {2'b00, div};
    q_bit   = ~diff[VW+1];
    rem_out = q_bit ? diff[VW:0] : shifted;
  end

endmodule

// File: rtl/divider_6.sv
// Sequential sign-magnitude restoring divider, one quotient bit per clock; DIVIDER_6_ROUND_EN enables round-half-up.
// Latency: rdy pulses DW+1 edges after the start edge (17 at default), fixed for all operands.
// Backpressure: start is ignored while busy; accepted again on the edge after rdy.
module divider_6
  import divider_6_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW:0]   dividend,
  input  logic [VW:0]   divisor,
  output logic [DW:0]   quot,
  output logic [VW-1:0] rem,
  output logic          busy,
  output logic          rdy,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

`ifdef DIVIDER_6_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW:0]   pr;       // partial remainder
  logic [DW-1:0] qr;       // dividend bits shifting out, quotient bits shifting in
  logic [VW-1:0] dvs;      // divisor magnitude
  logic [VW-1:0] dvd_lo;   // low dividend bits reported as remainder on divide-by-zero
  logic          s_dvd;
  logic          s_dvs;
  logic          dz;

  logic [VW:0]   pr_nxt;
  logic          q_bit;

  logic          round_up;
  logic [DW-1:0] fin_mag;
  logic          fin_sign;
  logic [VW-1:0] fin_rem;

  div_step_6 #(.VW(VW)) u_step (
    .rem_in  (pr),
    .bit_in  (qr[DW-1]),
    .div     (dvs),
    .rem_out (pr_nxt),
    .q_bit   (q_bit)
  );

  // Final magnitude, sign and remainder from the completed iteration registers.
  always_comb begin
    round_up = ROUND_EN && ({pr[VW-1:0], 1'b0} >= {1'b0, dvs});
    if (dz) begin
      fin_mag = {DW{1'b1}};
    end else if (round_up && (qr != {DW{1'b1}})) begin
      fin_mag = qr + 1'b1;
    end else begin
      fin_mag = qr;
    end
    // No negative zero.
    fin_sign = (s_dvd ^ s_dvs) & (|fin_mag);
    fin_rem  = dz ? dvd_lo : pr[VW-1:0];
  end

  // Control FSM plus datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pr       <= '0;
      qr       <= '0;
      dvs      <= '0;
      dvd_lo   <= '0;
      s_dvd    <= 1'b0;
      s_dvs    <= 1'b0;
      dz       <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      rdy      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy <= 1'b0;
          if (start) begin
            qr       <= dividend[DW-1:0];
            dvd_lo   <= dividend[VW-1:0];
            s_dvd    <= dividend[DW];
            dvs      <= divisor[VW-1:0];
            s_dvs    <= divisor[VW];
            dz       <= (divisor[VW-1:0] == '0);
            pr       <= '0;
            cnt      <= CW'(DW - 1);
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          pr  <= pr_nxt;
          qr  <= {qr[DW-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          quot     <= {fin_sign, fin_mag};
          rem      <= fin_rem;
          div_zero <= dz;
          rdy      <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
